coefficient_block_assembler: RTL

- Downstream neighbour of the number generator. Consumes its per-coefficient events (zero run, coefficient, strobe).
- Expands run-length/EOB/ZRL codes into a full 64-entry 8x8 block. Undoes zigzag ordering and streams the block in natural raster order to the dequantiser/IDCT over a valid/ready handshake.
- Ping-pong buffered: one bank fills while the other drains.

---
 rtl/coefficient_block_assembler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/coefficient_block_assembler.sv
// coefficient_block_assembler
// Turns run-length coded coefficient events (zero run, value, strobe) into
// full 8x8 blocks, undoes zigzag ordering and streams each block in natural
// raster order over a valid/ready handshake. Two banks ping-pong: one fills
// while the other drains.
// Optional build macro: DC_PREDICT_EN -- DC events are differences against a
// running predictor (cleared by rst or dc_restart).
module coefficient_block_assembler #(
  parameter int COEF_W     = 8,
  parameter int BLOCK_SIZE = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        s_value,
  input  logic [COEF_W-1:0] coefficient,
  input  logic              is_new_coefficient,
  input  logic              dc_restart,
  output logic              in_ready,
  output logic [COEF_W-1:0] out_coefficient,
  output logic [5:0]        out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overflow_error,
  output logic              index_error
);

  localparam logic [6:0] BLOCK_END = 7'(BLOCK_SIZE);
  localparam logic [6:0] LAST_POS  = 7'(BLOCK_SIZE - 1);
  localparam logic [5:0] LAST_IDX  = 6'(BLOCK_SIZE - 1);
  localparam logic [3:0] ZRL_RUN   = 4'd15;
  localparam logic [6:0] ZRL_SKIP  = 7'd16;

  // Zigzag position -> natural (row*8+col) address, standard JPEG order.
  localparam logic [5:0] ZZ_NAT [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [COEF_W-1:0] bank [2][BLOCK_SIZE];
  logic              fill_bank;
  logic              read_bank;
  logic [1:0]        bank_full;
  logic [6:0]        zz_idx;
  logic [5:0]        rd_idx;

  logic              accept;
  logic              xfer;
  logic [6:0]        run_pos;
  logic [COEF_W-1:0] dc_value;
  logic              wr_en;
  logic [5:0]        wr_addr;
  logic [COEF_W-1:0] wr_data;
  logic [6:0]        next_zz;
  logic              run_error;
  logic              complete;

  assign in_ready        = ~bank_full[fill_bank];
  assign accept          = is_new_coefficient & in_ready;
  assign out_valid       = bank_full[read_bank];
  assign out_coefficient = bank[read_bank][rd_idx];
  assign out_index       = rd_idx;
  assign out_last        = out_valid & (rd_idx == LAST_IDX);
  assign xfer            = out_valid & out_ready;
  assign run_pos         = zz_idx + {3'b000, s_value};

`ifdef DC_PREDICT_EN
  logic [COEF_W-1:0] dc_pred;
  logic [COEF_W-1:0] dc_base;

  // A same-cycle restart makes the incoming DC difference start from zero.
  assign dc_base  = dc_restart ? '0 : dc_pred;
  assign dc_value = dc_base + coefficient;

  // Predictor tracks the last stored DC; restart clears it when no DC lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      dc_pred <= '0;
    end else if (accept && (zz_idx == 7'd0)) begin
      dc_pred <= dc_value;
    end else if (dc_restart) begin
      dc_pred <= '0;
    end
  end
`else
  logic unused_dc_restart;

  assign dc_value          = coefficient;
  assign unused_dc_restart = dc_restart;
`endif

  // Decode one event into a write request and the next zigzag position.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = coefficient;
    next_zz   = zz_idx;
    run_error = 1'b0;
    if (zz_idx == 7'd0) begin
      wr_en   = 1'b1;
      wr_addr = ZZ_NAT[0];
      wr_data = dc_value;
      next_zz = 7'd1;
    end else if ((s_value == 4'd0) && (coefficient == '0)) begin
      next_zz = BLOCK_END;
    end else if ((s_value == ZRL_RUN) && (coefficient == '0)) begin
      next_zz = zz_idx + ZRL_SKIP;
    end else if (run_pos > LAST_POS) begin
      run_error = 1'b1;
      next_zz   = BLOCK_END;
    end else begin
      wr_en   = 1'b1;
      wr_addr = ZZ_NAT[run_pos[5:0]];
      next_zz = run_pos + 7'd1;
    end
    complete = (next_zz >= BLOCK_END);
  end

  // Fill bank writes, drain bank re-zeroing, bank hand-off and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is reset explicitly because zero runs never write;
      // every entry must start at zero for skipped positions to read back 0.
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < BLOCK_SIZE; i++) begin
          bank[b][i] <= '0;
        end
      end
      fill_bank      <= 1'b0;
      read_bank      <= 1'b0;
      bank_full      <= 2'b00;
      zz_idx         <= '0;
      rd_idx         <= '0;
      overflow_error <= 1'b0;
      index_error    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so fill and drain updates to the two
      // banks in the same edge both see pre-edge state and both take effect.
      if (accept) begin
        if (wr_en) begin
          bank[fill_bank][wr_addr] <= wr_data;
        end
        if (run_error) begin
          index_error <= 1'b1;
        end
        if (complete) begin
          bank_full[fill_bank] <= 1'b1;
          fill_bank            <= ~fill_bank;
          zz_idx               <= '0;
        end else begin
          zz_idx <= next_zz;
        end
      end
      if (is_new_coefficient && !in_ready) begin
        overflow_error <= 1'b1;
      end
      if (xfer) begin
        bank[read_bank][rd_idx] <= '0;
        if (out_last) begin
          rd_idx               <= '0;
          bank_full[read_bank] <= 1'b0;
          read_bank            <= ~read_bank;
        end else begin
          rd_idx <= rd_idx + 6'd1;
        end
      end
    end
  end

endmodule
